// File: rtl/pit_scheduler.sv
// Round-robin owner arbitration for one shared interval timer among four requesters,
// with a per-transaction watchdog so a timer that never fires cannot hang the bus.
`timescale 1ns/1ps
module pit_scheduler #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [63:0] req_count,
    output logic [3:0]  grant,
    output logic [3:0]  done,
    output logic        err,
    output logic        busy,
    output logic        pit_write_enable,
    output logic [7:0]  pit_counter_high,
    output logic [7:0]  pit_counter_low,
    output logic        pit_repeating,
    output logic        pit_divider_on,
    input  logic        pit_counter_set,
    input  logic        pit_interrupting
);
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, PROGRAM, WAIT_SET, RUN, DONE} state_t;

    state_t         state;
    state_t         state_next;
    logic [1:0]     idx;
    logic [1:0]     last_idx;
    logic [1:0]     sel_idx;
    logic           sel_found;
    logic [15:0]    count;
    logic [15:0]    sel_count;
    logic [WDW-1:0] wdog;
    logic           err_q;
    logic           err_next;
    logic           load;
    logic           wd_expired;

    // Search starts one past the previous owner so every requester gets a turn.
    always_comb begin
        sel_idx   = 2'd0;
        sel_found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!sel_found && req[last_idx + 2'(k)]) begin
                sel_idx   = last_idx + 2'(k);
                sel_found = 1'b1;
            end
        end
    end

    assign sel_count  = req_count[{sel_idx, 4'b0000} +: 16];
    assign wd_expired = (wdog == WD_LAST);

    always_comb begin
        state_next = state;
        load       = 1'b0;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    load       = 1'b1;
                    state_next = (sel_count != 16'd0) ? PROGRAM : DONE;
                end
            end
            PROGRAM: state_next = WAIT_SET;
            WAIT_SET: begin
                if (wd_expired) begin
                    state_next = DONE;
                    err_next   = 1'b1;
                end else if (pit_counter_set) begin
                    state_next = RUN;
                end
            end
            // A real interrupt on the expiry cycle still counts as success.
            RUN: begin
                if (pit_interrupting) begin
                    state_next = DONE;
                end else if (wd_expired) begin
                    state_next = DONE;
                    err_next   = 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // last_idx resets to 3 so that requester 0 is the first one searched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= 2'd0;
            last_idx <= 2'd3;
            count    <= 16'd0;
            wdog     <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= err_next;
            if (load) begin
                idx   <= sel_idx;
                count <= sel_count;
            end
            if (state == DONE) begin
                last_idx <= idx;
            end
            if (state == WAIT_SET || state == RUN) begin
                wdog <= wdog + 1'b1;
            end else begin
                wdog <= '0;
            end
        end
    end

    always_comb begin
        grant = 4'b0000;
        done  = 4'b0000;
        if (state != IDLE) begin
            grant[idx] = 1'b1;
        end
        if (state == DONE) begin
            done[idx] = 1'b1;
        end
    end

    assign err              = (state == DONE) && err_q;
    assign busy             = (state != IDLE);
    assign pit_write_enable = (state == PROGRAM);
    assign pit_counter_high = count[15:8];
    assign pit_counter_low  = count[7:0];
    assign pit_repeating    = 1'b0;
    assign pit_divider_on   = 1'b0;
endmodule

// File: tb/tb_pit_scheduler.sv
// Randomised scoreboard bench for pit_scheduler: a transaction-level model predicts
// winner, latched count, error flag and completion cycle; a monitor checks the DUT.
`timescale 1ns/1ps
module tb_pit_scheduler;
    localparam int T = 16;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [63:0] req_count;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        err;
    logic        busy;
    logic        pit_write_enable;
    logic [7:0]  pit_counter_high;
    logic [7:0]  pit_counter_low;
    logic        pit_repeating;
    logic        pit_divider_on;
    logic        pit_counter_set;
    logic        pit_interrupting;

    typedef struct {
        int          idx;
        int          err;
        logic [15:0] count;
        bit          has_write;
        int          write_cyc;
        int          done_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;
    int   cyc          = 0;
    int   model_last   = 3;
    int   pit_s        = 0;
    int   pit_r        = -1;
    bit   pit_spur     = 1'b0;

    pit_scheduler #(.TIMEOUT(T)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req              (req),
        .req_count        (req_count),
        .grant            (grant),
        .done             (done),
        .err              (err),
        .busy             (busy),
        .pit_write_enable (pit_write_enable),
        .pit_counter_high (pit_counter_high),
        .pit_counter_low  (pit_counter_low),
        .pit_repeating    (pit_repeating),
        .pit_divider_on   (pit_divider_on),
        .pit_counter_set  (pit_counter_set),
        .pit_interrupting (pit_interrupting)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish, got running required finished");
        $fatal(1, "[TB] global timeout");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    // Timer model: counter_set s cycles and interrupt r cycles after WAIT_SET entry (r<0: never).
    initial begin
        pit_counter_set  = 1'b0;
        pit_interrupting = 1'b0;
        forever begin
            @(negedge clk);
            pit_counter_set  = 1'b0;
            pit_interrupting = 1'b0;
            if (rst_n && pit_write_enable) begin
                int s;
                int r;
                int kmax;
                bit spur;
                s    = pit_s;
                r    = pit_r;
                spur = pit_spur;
                kmax = 1 + ((r > s) ? r : s);
                for (int k = 1; k <= kmax; k++) begin
                    @(negedge clk);
                    pit_counter_set  = (k == 1 + s);
                    pit_interrupting = (k == 1 + r) || (spur && s >= 1 && k == 1);
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                checkOutput("grant_at_most_one", 64'($countones(grant) <= 1), 64'd1);
                checkOutput("done_at_most_one", 64'($countones(done) <= 1), 64'd1);
                checkOutput("pit_mode_ties", {pit_repeating, pit_divider_on}, 64'd0);
                if (done == 4'b0000) checkOutput("err_without_done", err, 64'd0);
                if (pit_write_enable) begin
                    if (sb.size() == 0) begin
                        checkOutput("write_unexpected", pit_write_enable, 64'd0);
                    end else begin
                        e = sb[0];
                        checkOutput("write_expected", pit_write_enable, e.has_write);
                        checkOutput("write_cycle", cyc, e.write_cyc);
                        checkOutput("write_count", {pit_counter_high, pit_counter_low}, e.count);
                        checkOutput("write_grant", grant, 4'b0001 << e.idx);
                    end
                end
                if (done != 4'b0000) begin
                    if (sb.size() == 0) begin
                        checkOutput("done_unexpected", done, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("done_vector", done, 4'b0001 << e.idx);
                        checkOutput("done_err", err, e.err);
                        checkOutput("done_cycle", cyc, e.done_cyc);
                        checkOutput("done_grant", grant, 4'b0001 << e.idx);
                        checkOutput("done_busy", busy, 64'd1);
                        checkOutput("held_count", {pit_counter_high, pit_counter_low}, e.count);
                    end
                end
            end
        end
    end

    // lead = cycles until the DUT's selection edge (1 from IDLE, 2 from DONE).
    task automatic applyStimulus(input logic [3:0] r_req, input logic [63:0] counts,
                                 input int s, input int r, input bit spur, input int lead);
        exp_t        e;
        int          w;
        logic [1:0]  c2;
        logic [15:0] c16;
        w = -1;
        for (int k = 1; k <= 4; k++) begin
            c2 = 2'((model_last + k) % 4);
            if (w < 0 && r_req[c2]) w = int'(c2);
        end
        model_last = w;
        c16 = counts[16*w +: 16];
        e.idx       = w;
        e.count     = c16;
        e.has_write = (c16 != 16'd0);
        e.write_cyc = cyc + lead;
        if (c16 == 16'd0) begin
            e.err      = 0;
            e.done_cyc = cyc + lead;
        end else begin
            int wait_start;
            bit clean;
            wait_start = cyc + lead + 1;
            clean      = (s <= T - 2) && (r >= s + 1) && (r <= T - 1);
            e.err      = clean ? 0 : 1;
            e.done_cyc = clean ? wait_start + r + 1 : wait_start + T;
        end
        sb.push_back(e);
        pit_s     = s;
        pit_r     = r;
        pit_spur  = spur;
        req       = r_req;
        req_count = counts;
    endtask

    task automatic runTxn(input logic [3:0] r_req, input logic [63:0] counts, input int s,
                          input int r, input bit spur, input int lead, input bit mutate);
        int k;
        applyStimulus(r_req, counts, s, r, spur, lead);
        for (int i = 1; i < lead; i++) begin
            @(negedge clk);
            checkOutput("gap_busy", busy, 64'd0);
            checkOutput("gap_grant", grant, 64'd0);
        end
        @(negedge clk);
        if (mutate) begin
            req       = 4'($urandom_range(0, 15));
            req_count = {$urandom, $urandom};
        end
        k = 0;
        while (done == 4'b0000 && k < 60) begin
            @(negedge clk);
            k++;
        end
        checkOutput("done_within_bound", 64'(done != 4'b0000), 64'd1);
    endtask

    task automatic goIdle();
        req = 4'b0000;
        repeat (3) begin
            @(negedge clk);
            checkOutput("idle_busy", busy, 64'd0);
            checkOutput("idle_grant", grant, 64'd0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = 4'b0000;
        req_count = 64'd0;
        #2;
        checkOutput("reset_grant", grant, 64'd0);
        checkOutput("reset_done", done, 64'd0);
        checkOutput("reset_err", err, 64'd0);
        checkOutput("reset_busy", busy, 64'd0);
        checkOutput("reset_write", pit_write_enable, 64'd0);
        checkOutput("reset_counter", {pit_counter_high, pit_counter_low}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            runTxn(4'b1111, {4{16'd5}}, 0, 3, 1'b0, (i == 0) ? 1 : 2, 1'b0);
        end
        goIdle();
        runTxn(4'b0001, 64'h0000_0000_0000_000A, 1, 11, 1'b0, 1, 1'b0);
        goIdle();
        runTxn(4'b0010, {16'h0, 16'h0, 16'h1234, 16'h0}, 3, -1, 1'b0, 1, 1'b0);
        goIdle();
        runTxn(4'b0100, {16'h7777, 16'h0000, 16'h5555, 16'h6666}, 0, 3, 1'b0, 1, 1'b0);
        runTxn(4'b1000, {16'h0007, 48'h0}, 0, 15, 1'b0, 2, 1'b0);
        runTxn(4'b1000, {16'h0009, 48'h0}, 15, -1, 1'b0, 2, 1'b0);
        runTxn(4'b0001, 64'h0000_0000_0000_0003, 2, 15, 1'b1, 2, 1'b1);

        for (int i = 0; i < 60; i++) begin
            logic [63:0] cnts;
            int          s;
            int          r;
            int          mode;
            bit          spur;
            for (int j = 0; j < 4; j++) begin
                cnts[16*j +: 16] = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom);
            end
            mode = int'($urandom_range(0, 9));
            s    = int'($urandom_range(0, 8));
            spur = 1'($urandom_range(0, 1));
            if (mode == 0) begin
                s = int'($urandom_range(0, 15));
                r = -1;
            end else if (mode == 1) begin
                r = 15;
            end else if (mode == 2) begin
                r = int'($urandom_range(16, 17));
            end else begin
                r = s + 1 + int'($urandom_range(0, 14 - s));
            end
            if ($urandom_range(0, 1) == 1) begin
                runTxn(4'($urandom_range(1, 15)), cnts, s, r, spur, 2, 1'($urandom_range(0, 1)));
            end else begin
                goIdle();
                runTxn(4'($urandom_range(1, 15)), cnts, s, r, spur, 1, 1'($urandom_range(0, 1)));
            end
        end

        // Abort a transaction in RUN; nothing may complete and requester 0 wins afterwards.
        applyStimulus(4'b0010, {16'h0, 16'h0, 16'h0042, 16'h0}, 1, -1, 1'b0, 2);
        @(negedge clk);
        @(negedge clk);
        repeat (4) @(negedge clk);
        checkOutput("pre_reset_busy", busy, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_grant", grant, 64'd0);
        checkOutput("async_reset_done", done, 64'd0);
        checkOutput("async_reset_err", err, 64'd0);
        checkOutput("async_reset_busy", busy, 64'd0);
        checkOutput("async_reset_write", pit_write_enable, 64'd0);
        checkOutput("async_reset_counter", {pit_counter_high, pit_counter_low}, 64'd0);
        sb.delete();
        model_last = 3;
        req        = 4'b0000;
        repeat (3) begin
            @(negedge clk);
            checkOutput("reset_no_done", done, 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        runTxn(4'b1111, {4{16'h0011}}, 0, 4, 1'b0, 1, 1'b0);
        goIdle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
